// File: rtl/ucdp_afifo_wrarb_pkg.sv
// State encoding shared by the ucdp_afifo write-port burst arbiter.
package ucdp_afifo_wrarb_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_BURST  = 2'd1;
   localparam logic [1:0] ST_SETTLE = 2'd2;

   typedef enum logic [1:0] {
      IDLE   = ST_IDLE,
      BURST  = ST_BURST,
      SETTLE = ST_SETTLE
   } state_e;

endpackage

// File: rtl/ucdp_rr_arb.sv
// Combinational round-robin pick: first eligible index after ptr_i, wrapping.
// Pointer storage lives in the caller.
module ucdp_rr_arb #(
   parameter int num_req_p = 4,
   parameter int idx_w_p   = $clog2(num_req_p)
) (
   input  logic [num_req_p-1:0] elig_i,
   input  logic [idx_w_p-1:0]   ptr_i,
   output logic [num_req_p-1:0] win_oh_o,
   output logic [idx_w_p-1:0]   win_idx_o,
   output logic                 win_vld_o
);

   always_comb begin
      int idx;
      idx       = 0;
      win_oh_o  = '0;
      win_idx_o = '0;
      win_vld_o = 1'b0;
      // k = num_req_p revisits ptr_i itself, so the last owner still wins when alone.
      for (int k = 1; k <= num_req_p; k++) begin
         idx = (int'(ptr_i) + k) % num_req_p;
         if (!win_vld_o && elig_i[idx]) begin
            win_vld_o     = 1'b1;
            win_oh_o[idx] = 1'b1;
            win_idx_o     = idx_w_p'(idx);
         end
      end
   end

endmodule

// File: rtl/ucdp_afifo_wrarb.sv
// Round-robin burst arbiter for the ucdp_afifo write port; a burst is granted only when it fits entirely.
// Optional idle-beat watchdog enabled by UCDP_AFIFO_WRARB_WDOG_EN.
module ucdp_afifo_wrarb
   import ucdp_afifo_wrarb_pkg::*;
#(
   parameter int num_req_p     = 4,
   parameter int dwidth_p      = 8,
   parameter int awidth_p      = 4,
   parameter int lenwidth_p    = 3,
   parameter int wdog_cycles_p = 16
) (
   input  logic                            src_clk_i,
   input  logic                            src_rst_an_i,
   input  logic [num_req_p-1:0]            req_i,
   input  logic [num_req_p*lenwidth_p-1:0] len_i,
   input  logic [num_req_p-1:0]            valid_i,
   input  logic [num_req_p*dwidth_p-1:0]   data_i,
   output logic [num_req_p-1:0]            gnt_o,
   output logic [num_req_p-1:0]            ack_o,
   output logic                            fifo_wr_en_o,
   output logic [dwidth_p-1:0]             fifo_wr_data_o,
   input  logic                            fifo_wr_full_i,
   input  logic [awidth_p-1:0]             fifo_wr_space_avail_i,
   output logic                            busy_o,
   output logic [num_req_p-1:0]            err_o
);

   localparam int iw_p = $clog2(num_req_p);
   localparam int cw_p = awidth_p + 1;

   if (num_req_p < 2 || num_req_p > 16) begin : g_bad_num_req
      $error("ucdp_afifo_wrarb: num_req_p out of range");
   end
   if ((1 << lenwidth_p) > (1 << (awidth_p - 1))) begin : g_bad_lenwidth
      $error("ucdp_afifo_wrarb: maximum burst exceeds FIFO depth");
   end
   if (wdog_cycles_p < 1) begin : g_bad_wdog
      $error("ucdp_afifo_wrarb: wdog_cycles_p must be at least 1");
   end

   state_e                 state_q, state_d;
   logic [iw_p-1:0]        owner_q, owner_d;
   logic [iw_p-1:0]        ptr_q, ptr_d;
   logic [lenwidth_p-1:0]  cnt_q, cnt_d;
   logic [num_req_p-1:0]   gnt_q, gnt_d;

   logic [num_req_p-1:0]   elig;
   logic [num_req_p-1:0]   win_oh;
   logic [iw_p-1:0]        win_idx;
   logic                   win_vld;
   logic [lenwidth_p-1:0]  win_len;
   logic [num_req_p-1:0]   owner_oh;
   logic                   own_vld;
   logic [dwidth_p-1:0]    own_dat;
   logic                   ack;
   logic                   wdog_abort;

   // Burst of len+1 beats must fit in the free space; widened so len+1 cannot wrap.
   always_comb begin
      logic [cw_p-1:0] need;
      need    = '0;
      elig    = '0;
      win_len = '0;
      for (int i = 0; i < num_req_p; i++) begin
         need    = cw_p'(len_i[i*lenwidth_p +: lenwidth_p]) + cw_p'(1);
         elig[i] = req_i[i] && (need <= {1'b0, fifo_wr_space_avail_i});
         if (win_idx == iw_p'(i)) begin
            win_len = len_i[i*lenwidth_p +: lenwidth_p];
         end
      end
   end

   ucdp_rr_arb #(
      .num_req_p (num_req_p),
      .idx_w_p   (iw_p)
   ) u_rr_arb (
      .elig_i    (elig),
      .ptr_i     (ptr_q),
      .win_oh_o  (win_oh),
      .win_idx_o (win_idx),
      .win_vld_o (win_vld)
   );

   always_comb begin
      owner_oh = '0;
      own_vld  = 1'b0;
      own_dat  = '0;
      for (int i = 0; i < num_req_p; i++) begin
         if (owner_q == iw_p'(i)) begin
            owner_oh[i] = 1'b1;
            own_vld     = valid_i[i];
            own_dat     = data_i[i*dwidth_p +: dwidth_p];
         end
      end
   end

   assign ack = (state_q == BURST) && own_vld && !fifo_wr_full_i;

`ifdef UCDP_AFIFO_WRARB_WDOG_EN
   localparam int wdw_p = $clog2(wdog_cycles_p + 1);

   logic [wdw_p-1:0] wdog_q, wdog_d;

   // Counts owner-idle BURST cycles; a full-stalled valid beat holds the count.
   always_comb begin
      wdog_d     = '0;
      wdog_abort = 1'b0;
      if (state_q == BURST && !ack) begin
         if (!own_vld) begin
            if (wdog_q == wdw_p'(wdog_cycles_p - 1)) begin
               wdog_abort = 1'b1;
            end else begin
               wdog_d = wdog_q + wdw_p'(1);
            end
         end else begin
            wdog_d = wdog_q;
         end
      end
   end

   always_ff @(posedge src_clk_i or negedge src_rst_an_i) begin
      if (!src_rst_an_i) begin
         wdog_q <= '0;
      end else begin
         wdog_q <= wdog_d;
      end
   end
`else
   assign wdog_abort = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      gnt_d   = '0;
      case (state_q)
         IDLE: begin
            if (win_vld) begin
               state_d = BURST;
               owner_d = win_idx;
               ptr_d   = win_idx;
               cnt_d   = win_len;
               gnt_d   = win_oh;
            end
         end
         BURST: begin
            if (ack) begin
               if (cnt_q == '0) begin
                  state_d = SETTLE;
               end else begin
                  cnt_d = cnt_q - lenwidth_p'(1);
               end
            end else if (wdog_abort) begin
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge src_clk_i or negedge src_rst_an_i) begin
      if (!src_rst_an_i) begin
         state_q <= IDLE;
         owner_q <= '0;
         ptr_q   <= iw_p'(num_req_p - 1);
         cnt_q   <= '0;
         gnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
      end
   end

   assign gnt_o          = gnt_q;
   assign ack_o          = ack ? owner_oh : '0;
   assign fifo_wr_en_o   = ack;
   assign fifo_wr_data_o = ack ? own_dat : '0;
   assign busy_o         = (state_q != IDLE);
   assign err_o          = wdog_abort ? owner_oh : '0;

endmodule
